// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci stack engine.
// FSM state codes and Fibonacci seed values.
package fib_pkg;
    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t PUSH = 2'd1;
    localparam state_t POP  = 2'd2;
    localparam state_t FIN  = 2'd3;

    localparam int FIB_BASE0 = 0;
    localparam int FIB_BASE1 = 1;
endpackage

// File: rtl/fib_stack_engine_lifo_stack.sv
// Registered LIFO with occupancy pointer.
// Top-of-stack read is combinational.
module lifo_stack
    import fib_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [SPW-1:0]   sp,
    output logic             full,
    output logic             empty,
    output logic             illegal
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   rd;

    assign rd      = sp - SPW'(1);
    assign full    = (sp == SPW'(DEPTH));
    assign empty   = (sp == '0);
    assign illegal = (push & full) | (pop & empty);
    assign dout    = mem[rd[AW-1:0]];

    // Contents need no reset; only sp defines what is valid.
    always_ff @(posedge clk) begin
        if (push && !full && !clr)
            mem[sp[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sp <= '0;
        else if (clr)
            sp <= '0;
        else if (push && !full)
            sp <= sp + SPW'(1);
        else if (pop && !empty)
            sp <= sp - SPW'(1);
    end
endmodule

// File: rtl/fib_stack_engine.sv
// Fibonacci engine: pushes n..2 onto a LIFO, then pops
// and accumulates fib(k) for each popped index k.
module fib_stack_engine
    import fib_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] n_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             err,
    output logic             zero,
    output logic [SPW-1:0]   sp
);
    localparam logic [WIDTH:0] NMAX = (WIDTH + 1)'(DEPTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a0, a1, a2;
    logic [WIDTH:0]   v0;
    logic [WIDTH-1:0] dout;
    logic             push, pop;
    logic             full, empty, illegal;
    logic             last, stk_fault;

    assign v0   = {1'b0, a1} + {1'b0, a2};
    assign push = (state == PUSH) && !abort;
    assign pop  = (state == POP) && !abort;
    assign last = (sp == SPW'(1));
    assign busy = (state != IDLE);
    assign done = (state == FIN) && !abort;

    // Stack misuse cannot happen in normal operation; flag it as err.
    assign stk_fault = illegal | (push & full) | (pop & empty)
                     | (pop & (dout < WIDTH'(2)));

    lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .SPW   (SPW)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (abort),
        .push    (push),
        .pop     (pop),
        .din     (a0),
        .dout    (dout),
        .sp      (sp),
        .full    (full),
        .empty   (empty),
        .illegal (illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a0     <= '0;
            a1     <= '0;
            a2     <= '0;
            result <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
            zero   <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            unique case (1'b1)
                (state == IDLE): begin
                    if (start) begin
                        a0  <= n_in;
                        ovf <= 1'b0;
                        err <= 1'b0;
                        if (n_in < WIDTH'(2)) begin
                            result <= n_in;
                            zero   <= (n_in == '0);
                            state  <= FIN;
                        end else if ({1'b0, n_in} > NMAX) begin
                            err    <= 1'b1;
                            result <= '0;
                            zero   <= 1'b1;
                            state  <= FIN;
                        end else begin
                            state <= PUSH;
                        end
                    end
                end
                (state == PUSH): begin
                    a0 <= a0 - WIDTH'(1);
                    if (stk_fault)
                        err <= 1'b1;
                    if (a0 == WIDTH'(2)) begin
                        a2    <= WIDTH'(FIB_BASE0);
                        a1    <= WIDTH'(FIB_BASE1);
                        state <= POP;
                    end
                end
                (state == POP): begin
                    a2 <= a1;
                    a1 <= v0[WIDTH-1:0];
                    if (v0[WIDTH])
                        ovf <= 1'b1;
                    if (stk_fault)
                        err <= 1'b1;
                    if (last) begin
                        result <= v0[WIDTH-1:0];
                        zero   <= (v0[WIDTH-1:0] == '0);
                        state  <= FIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fib_stack_engine.md
Name: fib_stack_engine

Overview:
- Parametrised hardware engine that computes Fibonacci(n) the way the recursive routine does. It first pushes the descending arguments onto an explicit LIFO stack, then pops and accumulates.
- Successor to the fixed 8-bit push/pop datapath. It adds configurable data width and stack depth, a start/busy/done handshake, overflow and depth-error detection, abort, and a zero flag.
- Sits beside the CPU datapath as a self-contained compute unit.

Parameters:
- WIDTH, 8, data width of n, the accumulators (a1, a2, v0) and the result.
- DEPTH, 16, stack entries; the largest legal n is DEPTH+1.
- SPW, $clog2(DEPTH+1), stack pointer width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE, no done pulse
- n_in  input  WIDTH  argument n, latched on an accepted start
- busy  output  1  high from the cycle after accept until done
- done  output  1  one-cycle pulse when result/flags are valid
- result  output  WIDTH  fib(n) mod 2^WIDTH; held until the next accepted start
- ovf  output  1  sticky per run: some addition carried out of WIDTH
- err  output  1  n exceeded DEPTH+1; result forced 0
- zero  output  1  result==0, valid with done
- sp  output  SPW  current stack occupancy (debug)

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; sp=0; busy=0, done=0, result=0, ovf=0, err=0, zero=0. Stack contents are don't-care.
- FSM states: IDLE, PUSH, POP, FIN.
- IDLE, on start=1 (accept cycle):
  - Latch a0=n_in; clear ovf and err.
  - If n_in<2: go to FIN with result=n_in.
  - Else if n_in-1>DEPTH: go to FIN with err=1, result=0.
  - Else go to PUSH.
- PUSH, one push per cycle:
  - stack[sp]=a0; sp++; a0--.
  - After the cycle that pushes a0==2, load a2=0, a1=1 and go to POP.
  - Exactly n-1 push cycles.
- POP, one pop per cycle:
  - v0=a1+a2 (WIDTH+1 bits); carry sets ovf; a2=a1; a1=v0[WIDTH-1:0]; sp--.
  - Popped value k is the Fibonacci index just produced; a1=fib(k) mod 2^WIDTH.
  - On the pop that takes sp from 1 to 0, capture result=v0[WIDTH-1:0] and go to FIN.
  - Exactly n-1 pop cycles.
- FIN: done=1 for this cycle only; zero=(result==0); busy=0 next; return to IDLE.
- Latency from the accept edge to the done cycle:
  - n>=2: 2n-1 cycles.
  - n<2 or error: 1 cycle.
- A new start is accepted in the cycle after FIN (back-to-back runs allowed).
- start while busy: ignored; no queuing.
- abort:
  - Priority over all other transitions in PUSH, POP and FIN.
  - Next state IDLE, sp=0, no done pulse; result/ovf/err keep their previous-run values.
  - abort in IDLE together with start: abort wins, start is dropped.
- Stack boundaries:
  - Push when full, or pop when empty, is unreachable by construction; the stack sub-module asserts an internal illegal flag.
  - Push when full: entry not written, sp not changed.
  - Pop when empty: sp not changed.
- n=DEPTH+1 fills the stack exactly (sp reaches DEPTH) with no error.
- Overflow: arithmetic wraps modulo 2^WIDTH; once set, ovf stays set for the rest of the run.
- Reset mid-run: immediate IDLE; all outputs return to their reset values.

Decomposition:
- Shared package fib_pkg:
  - State enum: IDLE=2'd0, PUSH=2'd1, POP=2'd2, FIN=2'd3.
  - Constants FIB_BASE0=0, FIB_BASE1=1.
- One sub-module: lifo_stack, parameters WIDTH and DEPTH.
  - Ports: clk, rst_n, push, pop, din, dout, sp, full, empty, illegal.
  - Registered memory; dout is combinational from stack[sp-1].
- The FSM and accumulators live in fib_stack_engine.

Test Plan:
1. n_in=10, start one cycle -> busy for 19 cycles; done pulse 19 cycles after accept; result=55, ovf=0, err=0, zero=0; sp peaks at 9.
2. n_in=0, then n_in=1 -> done 1 cycle after each accept; results 0 (zero=1) and 1 (zero=0); sp stays 0.
3. WIDTH=8, n_in=14 -> result=121 (377 mod 256), ovf=1; rerun with n_in=13 -> result=233, ovf=0 (cleared at accept).
4. DEPTH=16: n_in=17 -> sp reaches 16, result=1597 mod 256=61, ovf=1, err=0; n_in=18 -> done after 1 cycle, err=1, result=0, sp stays 0.
5. n_in=8; assert start again mid-run, then abort in cycle 5 -> second start ignored; no done; IDLE and sp=0 next cycle; a fresh n_in=6 run gives result=8.
6. rst_n low mid-POP of an n_in=12 run -> all outputs and sp read 0 before the next clock edge; after release, n_in=12 gives result=144.
